// File: rtl/float_rcp_share_ctrl_pkg.sv
// Shared types and the round-robin search used by the reciprocal share controller.
package float_rcp_share_pkg;

  localparam int N_REQ_MAX = 8;
  localparam int RCP_X_W   = 37;
  localparam int TAG_ID_W  = 3;

  // One tag stage: valid bit plus requester ID, sized for the largest requester count.
  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } rcp_tag_t;

  // Result of a round-robin search: any-winner flag, one-hot grant and winner index.
  typedef struct packed {
    logic                 any;
    logic [N_REQ_MAX-1:0] gnt;
    logic [TAG_ID_W-1:0]  idx;
  } rr_pick_t;

  // Lowest valid index at or above ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [N_REQ_MAX-1:0] valid,
                                       input logic [TAG_ID_W-1:0]  ptr,
                                       input int                   n);
    rr_pick_t res;
    int       j;
    res = '0;
    for (int off = 0; off < N_REQ_MAX; off++) begin
      if (off < n) begin
        j = int'(ptr) + off;
        if (j >= n) j = j - n;
        if (!res.any && valid[j[TAG_ID_W-1:0]]) begin
          res.any                    = 1'b1;
          res.gnt[j[TAG_ID_W-1:0]]   = 1'b1;
          res.idx                    = j[TAG_ID_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/float_rcp_share_ctrl_if.sv
// Requester, datapath and response signals of the reciprocal share controller.
interface float_rcp_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int X_W   = 37
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    req_sign;
  logic [8*N_REQ-1:0]  req_exp;
  logic [23*N_REQ-1:0] req_man;
  logic                rcp_a_sign;
  logic [7:0]          rcp_a_exp;
  logic [22:0]         rcp_a_man;
  logic                rcp_astall;
  logic [X_W-1:0]      rcp_x;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [X_W-1:0]      rsp_x;
  logic                busy;
  logic [ID_W+1:0]     inflight;

  modport slave (
    input  req_valid, req_sign, req_exp, req_man, rcp_x, rsp_ready,
    output req_ready, rcp_a_sign, rcp_a_exp, rcp_a_man, rcp_astall,
           rsp_valid, rsp_id, rsp_x, busy, inflight
  );

  modport master (
    output req_valid, req_sign, req_exp, req_man, rcp_x, rsp_ready,
    input  req_ready, rcp_a_sign, rcp_a_exp, rcp_a_man, rcp_astall,
           rsp_valid, rsp_id, rsp_x, busy, inflight
  );
endinterface

// File: rtl/float_rcp_rr_arb.sv
// Combinational round-robin arbiter; the pointer register lives in the parent.
module float_rcp_rr_arb
  import float_rcp_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx
);

  logic [N_REQ_MAX-1:0] req_ext;
  logic [TAG_ID_W-1:0]  ptr_ext;
  rr_pick_t             pick;
  logic                 unused_pick;

  // Widen to the package search width, pick a winner, narrow back to this instance.
  always_comb begin
    req_ext = '0;
    ptr_ext = '0;
    if (enable) req_ext[N_REQ-1:0] = req;
    ptr_ext[ID_W-1:0] = ptr;
    pick = rr_pick(req_ext, ptr_ext, N_REQ);
    gnt  = pick.gnt[N_REQ-1:0];
    idx  = pick.idx[ID_W-1:0];
  end

  assign unused_pick = ^{pick.any, pick.gnt, pick.idx};

endmodule

// File: rtl/float_rcp_share_ctrl.sv
// Shares one pipelined reciprocal datapath between N_REQ requesters, tracking
// requester IDs in a tag pipe that stalls in lock-step with the datapath.
module float_rcp_share_ctrl
  import float_rcp_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int LAT   = 1,
  parameter int X_W   = RCP_X_W
) (
  input logic                   aclk,
  input logic                   aresetn,
  float_rcp_share_ctrl_if.slave bus
);

  rcp_tag_t         tag_q [LAT];
  rcp_tag_t         tag_d [LAT];
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  rr_ptr_d;
  logic             stall;
  logic             fire;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  g_idx;
  logic [ID_W-1:0]  sel;
  logic [ID_W+1:0]  pop;
  logic             unused_tag_id;

  // A valid tail the consumer is not taking freezes the whole pipe; reset masks it.
  assign stall = aresetn & tag_q[LAT-1].v & ~bus.rsp_ready;

  float_rcp_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (bus.req_valid),
    .ptr    (rr_ptr_q),
    .enable (aresetn & ~stall),
    .gnt    (gnt),
    .idx    (g_idx)
  );

  assign fire          = |gnt;
  assign bus.req_ready = gnt;
  assign bus.rcp_astall = stall;

  // Operand mux: the winner, or the pointer's requester when nobody wins.
  always_comb begin
    sel            = fire ? g_idx : rr_ptr_q;
    bus.rcp_a_sign = 1'b0;
    bus.rcp_a_exp  = '0;
    bus.rcp_a_man  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel == ID_W'(i)) begin
        bus.rcp_a_sign = bus.req_sign[i];
        bus.rcp_a_exp  = bus.req_exp[8*i +: 8];
        bus.rcp_a_man  = bus.req_man[23*i +: 23];
      end
    end
  end

  // Next tag pipe contents and round-robin pointer.
  always_comb begin
    for (int k = 0; k < LAT; k++) tag_d[k] = tag_q[k];
    rr_ptr_d = rr_ptr_q;
    if (!stall) begin
      tag_d[0].v  = fire;
      tag_d[0].id = '0;
      tag_d[0].id[ID_W-1:0] = g_idx;
      for (int k = 1; k < LAT; k++) tag_d[k] = tag_q[k-1];
    end
    if (fire) begin
      rr_ptr_d = (g_idx == ID_W'(N_REQ-1)) ? '0 : g_idx + 1'b1;
    end
  end

  // Tag and pointer registers; reset drops every in-flight tag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
      rr_ptr_q <= '0;
    end else begin
      for (int k = 0; k < LAT; k++) tag_q[k] <= tag_d[k];
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Occupancy count of the tag pipe.
  always_comb begin
    pop = '0;
    for (int k = 0; k < LAT; k++) pop = pop + {{(ID_W+1){1'b0}}, tag_q[k].v};
  end

  assign bus.rsp_valid = aresetn & tag_q[LAT-1].v;
  assign bus.rsp_id    = tag_q[LAT-1].id[ID_W-1:0];
  assign bus.rsp_x     = bus.rcp_x;
  assign bus.busy      = aresetn & (pop != '0);
  assign bus.inflight  = aresetn ? pop : '0;

  assign unused_tag_id = ^tag_q[LAT-1].id;

endmodule

// File: tb/tb_float_rcp_share_ctrl.sv
// Directed and random checks of the reciprocal share controller at LAT=1 and LAT=3.
module tb_float_rcp_share_ctrl;

  logic aclk = 1'b0;
  logic aresetn;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 aclk = ~aclk;

  float_rcp_share_ctrl_if #(.N_REQ(4), .ID_W(2), .X_W(37)) bus1 ();
  float_rcp_share_ctrl_if #(.N_REQ(4), .ID_W(2), .X_W(37)) bus3 ();

  float_rcp_share_ctrl #(.N_REQ(4), .ID_W(2), .LAT(1), .X_W(37)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .bus(bus1));
  float_rcp_share_ctrl #(.N_REQ(4), .ID_W(2), .LAT(3), .X_W(37)) dut3 (
    .aclk(aclk), .aresetn(aresetn), .bus(bus3));

  // Lane 0 drives the LAT=1 instance, lane 1 the LAT=3 instance.
  logic [3:0]  req_valid [2];
  logic [3:0]  req_sign  [2];
  logic [31:0] req_exp   [2];
  logic [91:0] req_man   [2];
  logic        rsp_ready [2];

  logic [3:0]  o_req_ready [2];
  logic        o_rsp_valid [2];
  logic [1:0]  o_rsp_id    [2];
  logic [36:0] o_rsp_x     [2];
  logic        o_astall    [2];
  logic        o_busy      [2];
  logic [3:0]  o_inflight  [2];

  logic [38:0] sbq0 [$];
  logic [38:0] sbq1 [$];

  assign bus1.req_valid = req_valid[0];
  assign bus1.req_sign  = req_sign[0];
  assign bus1.req_exp   = req_exp[0];
  assign bus1.req_man   = req_man[0];
  assign bus1.rsp_ready = rsp_ready[0];
  assign bus3.req_valid = req_valid[1];
  assign bus3.req_sign  = req_sign[1];
  assign bus3.req_exp   = req_exp[1];
  assign bus3.req_man   = req_man[1];
  assign bus3.rsp_ready = rsp_ready[1];

  assign o_req_ready[0] = bus1.req_ready;
  assign o_rsp_valid[0] = bus1.rsp_valid;
  assign o_rsp_id[0]    = bus1.rsp_id;
  assign o_rsp_x[0]     = bus1.rsp_x;
  assign o_astall[0]    = bus1.rcp_astall;
  assign o_busy[0]      = bus1.busy;
  assign o_inflight[0]  = bus1.inflight;
  assign o_req_ready[1] = bus3.req_ready;
  assign o_rsp_valid[1] = bus3.rsp_valid;
  assign o_rsp_id[1]    = bus3.rsp_id;
  assign o_rsp_x[1]     = bus3.rsp_x;
  assign o_astall[1]    = bus3.rcp_astall;
  assign o_busy[1]      = bus3.busy;
  assign o_inflight[1]  = bus3.inflight;

  // Stand-in reciprocal datapath function.
  function automatic logic [36:0] rcp_model(input logic s, input logic [7:0] e, input logic [22:0] m);
    return {s, 8'd253 - e, ~m, 5'h0B};
  endfunction

  // Stall-gated datapath registers without reset.
  logic [36:0] dp1_q;
  logic [36:0] dp3_q [3];

  always_ff @(posedge aclk) begin
    if (!bus1.rcp_astall) dp1_q <= rcp_model(bus1.rcp_a_sign, bus1.rcp_a_exp, bus1.rcp_a_man);
  end

  always_ff @(posedge aclk) begin
    if (!bus3.rcp_astall) begin
      dp3_q[0] <= rcp_model(bus3.rcp_a_sign, bus3.rcp_a_exp, bus3.rcp_a_man);
      dp3_q[1] <= dp3_q[0];
      dp3_q[2] <= dp3_q[1];
    end
  end

  assign bus1.rcp_x = dp1_q;
  assign bus3.rcp_x = dp3_q[2];

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    for (int l = 0; l < 2; l++) begin
      req_valid[l] = '0;
      rsp_ready[l] = 1'b1;
    end
  endtask

  task automatic set_op(input int l, input int i, input logic s, input logic [7:0] e, input logic [22:0] m);
    req_sign[l][i]       = s;
    req_exp[l][8*i +: 8] = e;
    req_man[l][23*i +: 23] = m;
  endtask

  function automatic logic [36:0] exp_x(input int l, input int i);
    return rcp_model(req_sign[l][i], req_exp[l][8*i +: 8], req_man[l][23*i +: 23]);
  endfunction

  task automatic test_reset();
    aresetn = 1'b0;
    for (int l = 0; l < 2; l++) begin
      req_valid[l] = 4'hF;
      rsp_ready[l] = 1'b1;
    end
    tick(); #1;
    for (int l = 0; l < 2; l++) begin
      n_cmp++; if (o_req_ready[l] !== 4'b0000) begin n_err++; $display("[TB] FAIL reset_req_ready lane%0d: got %b expected 0000", l, o_req_ready[l]); end
      n_cmp++; if (o_rsp_valid[l] !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rsp_valid lane%0d: got %b expected 0", l, o_rsp_valid[l]); end
      n_cmp++; if (o_busy[l] !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy lane%0d: got %b expected 0", l, o_busy[l]); end
      n_cmp++; if (o_inflight[l] !== 4'd0) begin n_err++; $display("[TB] FAIL reset_inflight lane%0d: got %0d expected 0", l, o_inflight[l]); end
    end
    tick(); tick();
    aresetn = 1'b1;
    idle_inputs();
    #1;
    for (int l = 0; l < 2; l++) begin
      n_cmp++; if (o_rsp_valid[l] !== 1'b0) begin n_err++; $display("[TB] FAIL post_reset_rsp_valid lane%0d: got %b expected 0", l, o_rsp_valid[l]); end
      n_cmp++; if (o_inflight[l] !== 4'd0) begin n_err++; $display("[TB] FAIL post_reset_inflight lane%0d: got %0d expected 0", l, o_inflight[l]); end
      n_cmp++; if (o_astall[l] !== 1'b0) begin n_err++; $display("[TB] FAIL post_reset_astall lane%0d: got %b expected 0", l, o_astall[l]); end
    end
  endtask

  task automatic test_all_valid();
    logic [3:0] expg;
    logic [1:0] expid;
    for (int i = 0; i < 4; i++) set_op(0, i, i[0], 8'(100 + 10*i), 23'(i * 32'h12345));
    for (int c = 0; c < 7; c++) begin
      tick();
      req_valid[0] = (c < 6) ? 4'hF : 4'h0;
      rsp_ready[0] = 1'b1;
      #1;
      if (c < 6) begin
        expg = 4'(1 << (c % 4));
        n_cmp++; if (o_req_ready[0] !== expg) begin n_err++; $display("[TB] FAIL rr_grant c%0d: got %b expected %b", c, o_req_ready[0], expg); end
      end
      if (c == 0) begin
        n_cmp++; if (o_rsp_valid[0] !== 1'b0) begin n_err++; $display("[TB] FAIL rr_first_rsp_valid: got %b expected 0", o_rsp_valid[0]); end
      end else begin
        expid = 2'((c - 1) % 4);
        n_cmp++; if (o_rsp_valid[0] !== 1'b1) begin n_err++; $display("[TB] FAIL rr_rsp_valid c%0d: got %b expected 1", c, o_rsp_valid[0]); end
        n_cmp++; if (o_rsp_id[0] !== expid) begin n_err++; $display("[TB] FAIL rr_rsp_id c%0d: got %0d expected %0d", c, o_rsp_id[0], expid); end
        n_cmp++; if (o_rsp_x[0] !== exp_x(0, int'(expid))) begin n_err++; $display("[TB] FAIL rr_rsp_x c%0d: got %h expected %h", c, o_rsp_x[0], exp_x(0, int'(expid))); end
      end
    end
  endtask

  task automatic test_single_op();
    tick();
    set_op(0, 2, 1'b0, 8'd127, 23'd0);
    req_valid[0] = 4'b0100;
    #1;
    n_cmp++; if (o_req_ready[0] !== 4'b0100) begin n_err++; $display("[TB] FAIL single_grant: got %b expected 0100", o_req_ready[0]); end
    n_cmp++; if (o_inflight[0] !== 4'd0) begin n_err++; $display("[TB] FAIL single_inflight0: got %0d expected 0", o_inflight[0]); end
    tick();
    req_valid[0] = 4'b0000;
    #1;
    n_cmp++; if (o_rsp_valid[0] !== 1'b1) begin n_err++; $display("[TB] FAIL single_rsp_valid: got %b expected 1", o_rsp_valid[0]); end
    n_cmp++; if (o_rsp_id[0] !== 2'd2) begin n_err++; $display("[TB] FAIL single_rsp_id: got %0d expected 2", o_rsp_id[0]); end
    n_cmp++; if (o_rsp_x[0] !== rcp_model(1'b0, 8'd127, 23'd0)) begin n_err++; $display("[TB] FAIL single_rsp_x: got %h expected %h", o_rsp_x[0], rcp_model(1'b0, 8'd127, 23'd0)); end
    n_cmp++; if (o_inflight[0] !== 4'd1) begin n_err++; $display("[TB] FAIL single_inflight1: got %0d expected 1", o_inflight[0]); end
    n_cmp++; if (o_busy[0] !== 1'b1) begin n_err++; $display("[TB] FAIL single_busy: got %b expected 1", o_busy[0]); end
    tick(); #1;
    n_cmp++; if (o_rsp_valid[0] !== 1'b0) begin n_err++; $display("[TB] FAIL single_rsp_done: got %b expected 0", o_rsp_valid[0]); end
    n_cmp++; if (o_inflight[0] !== 4'd0) begin n_err++; $display("[TB] FAIL single_inflight_end: got %0d expected 0", o_inflight[0]); end
  endtask

  task automatic test_wrap();
    logic [3:0] vin  [4];
    logic [3:0] gexp [4];
    vin[0] = 4'b0101; gexp[0] = 4'b0001;
    vin[1] = 4'b0101; gexp[1] = 4'b0100;
    vin[2] = 4'b0001; gexp[2] = 4'b0001;
    vin[3] = 4'b0000; gexp[3] = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      tick();
      req_valid[0] = vin[c];
      #1;
      n_cmp++; if (o_req_ready[0] !== gexp[c]) begin n_err++; $display("[TB] FAIL wrap_grant c%0d: got %b expected %b", c, o_req_ready[0], gexp[c]); end
      if (c > 0) begin
        n_cmp++; if (o_rsp_id[0] !== ((c == 2) ? 2'd2 : 2'd0)) begin n_err++; $display("[TB] FAIL wrap_rsp_id c%0d: got %0d", c, o_rsp_id[0]); end
      end
    end
  endtask

  task automatic test_backpressure();
    set_op(0, 1, 1'b1, 8'd130, 23'h2AAAAA);
    set_op(0, 3, 1'b0, 8'd60, 23'h012345);
    tick();
    req_valid[0] = 4'b0010;
    rsp_ready[0] = 1'b1;
    #1;
    n_cmp++; if (o_req_ready[0] !== 4'b0010) begin n_err++; $display("[TB] FAIL bp_grant1: got %b expected 0010", o_req_ready[0]); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      req_valid[0] = 4'b1000;
      rsp_ready[0] = 1'b0;
      #1;
      n_cmp++; if (o_astall[0] !== 1'b1) begin n_err++; $display("[TB] FAIL bp_astall c%0d: got %b expected 1", c, o_astall[0]); end
      n_cmp++; if (o_req_ready[0] !== 4'b0000) begin n_err++; $display("[TB] FAIL bp_req_ready c%0d: got %b expected 0000", c, o_req_ready[0]); end
      n_cmp++; if (o_rsp_valid[0] !== 1'b1 || o_rsp_id[0] !== 2'd1) begin n_err++; $display("[TB] FAIL bp_hold_id c%0d: got v=%b id=%0d expected v=1 id=1", c, o_rsp_valid[0], o_rsp_id[0]); end
      n_cmp++; if (o_rsp_x[0] !== exp_x(0, 1)) begin n_err++; $display("[TB] FAIL bp_hold_x c%0d: got %h expected %h", c, o_rsp_x[0], exp_x(0, 1)); end
    end
    tick();
    rsp_ready[0] = 1'b1;
    #1;
    n_cmp++; if (o_astall[0] !== 1'b0) begin n_err++; $display("[TB] FAIL bp_release_astall: got %b expected 0", o_astall[0]); end
    n_cmp++; if (o_req_ready[0] !== 4'b1000) begin n_err++; $display("[TB] FAIL bp_grant3: got %b expected 1000", o_req_ready[0]); end
    n_cmp++; if (o_rsp_id[0] !== 2'd1) begin n_err++; $display("[TB] FAIL bp_deliver1: got %0d expected 1", o_rsp_id[0]); end
    tick();
    req_valid[0] = 4'b0000;
    #1;
    n_cmp++; if (o_rsp_valid[0] !== 1'b1 || o_rsp_id[0] !== 2'd3) begin n_err++; $display("[TB] FAIL bp_deliver3: got v=%b id=%0d expected v=1 id=3", o_rsp_valid[0], o_rsp_id[0]); end
    n_cmp++; if (o_rsp_x[0] !== exp_x(0, 3)) begin n_err++; $display("[TB] FAIL bp_x3: got %h expected %h", o_rsp_x[0], exp_x(0, 3)); end
    tick(); #1;
    n_cmp++; if (o_rsp_valid[0] !== 1'b0) begin n_err++; $display("[TB] FAIL bp_no_dup: got %b expected 0", o_rsp_valid[0]); end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 4; i++) set_op(1, i, ~i[0], 8'(20 + 30*i), 23'(i * 32'h0F0F1 + 7));
    for (int c = 0; c < 3; c++) begin
      tick();
      req_valid[1] = 4'(1 << c);
      rsp_ready[1] = 1'b1;
      #1;
      n_cmp++; if (o_req_ready[1] !== 4'(1 << c)) begin n_err++; $display("[TB] FAIL mid_grant c%0d: got %b expected %b", c, o_req_ready[1], 4'(1 << c)); end
    end
    tick();
    req_valid[1] = 4'b0000;
    #1;
    n_cmp++; if (o_rsp_valid[1] !== 1'b1 || o_rsp_id[1] !== 2'd0) begin n_err++; $display("[TB] FAIL mid_first_rsp: got v=%b id=%0d expected v=1 id=0", o_rsp_valid[1], o_rsp_id[1]); end
    n_cmp++; if (o_inflight[1] !== 4'd3) begin n_err++; $display("[TB] FAIL mid_inflight3: got %0d expected 3", o_inflight[1]); end
    tick(); #1;
    n_cmp++; if (o_inflight[1] !== 4'd2) begin n_err++; $display("[TB] FAIL mid_inflight2: got %0d expected 2", o_inflight[1]); end
    aresetn = 1'b0;
    req_valid[1] = 4'b0001;
    #1;
    n_cmp++; if (o_rsp_valid[1] !== 1'b0) begin n_err++; $display("[TB] FAIL mid_reset_rsp_valid: got %b expected 0", o_rsp_valid[1]); end
    n_cmp++; if (o_req_ready[1] !== 4'b0000) begin n_err++; $display("[TB] FAIL mid_reset_req_ready: got %b expected 0000", o_req_ready[1]); end
    tick();
    aresetn = 1'b1;
    #1;
    n_cmp++; if (o_rsp_valid[1] !== 1'b0) begin n_err++; $display("[TB] FAIL after_reset_rsp_valid: got %b expected 0", o_rsp_valid[1]); end
    n_cmp++; if (o_inflight[1] !== 4'd0) begin n_err++; $display("[TB] FAIL after_reset_inflight: got %0d expected 0", o_inflight[1]); end
    n_cmp++; if (o_req_ready[1] !== 4'b0001) begin n_err++; $display("[TB] FAIL after_reset_grant: got %b expected 0001", o_req_ready[1]); end
    for (int c = 6; c < 10; c++) begin
      tick();
      req_valid[1] = 4'b0000;
      #1;
      n_cmp++; if (o_rsp_valid[1] !== (c == 8)) begin n_err++; $display("[TB] FAIL after_reset_stale c%0d: got %b expected %b", c, o_rsp_valid[1], (c == 8)); end
      if (c == 8) begin
        n_cmp++; if (o_rsp_id[1] !== 2'd0 || o_rsp_x[1] !== exp_x(1, 0)) begin n_err++; $display("[TB] FAIL after_reset_result: got id=%0d x=%h expected id=0 x=%h", o_rsp_id[1], o_rsp_x[1], exp_x(1, 0)); end
      end
    end
  endtask

  task automatic test_soak();
    logic [3:0]  acc [2];
    logic [38:0] ent;
    int          qs;
    acc[0] = '0;
    acc[1] = '0;
    for (int cyc = 0; cyc < 10012; cyc++) begin
      tick();
      for (int l = 0; l < 2; l++) begin
        req_valid[l] = req_valid[l] & ~acc[l];
        if (cyc < 10000) begin
          for (int i = 0; i < 4; i++) begin
            if (!req_valid[l][i] && $urandom_range(0, 1) == 1) begin
              set_op(l, i, 1'($urandom), 8'($urandom), 23'($urandom));
              req_valid[l][i] = 1'b1;
            end
          end
          rsp_ready[l] = ($urandom_range(0, 3) != 0);
        end else begin
          rsp_ready[l] = 1'b1;
        end
      end
      #1;
      for (int l = 0; l < 2; l++) begin
        n_cmp++; if (!$onehot0(o_req_ready[l]) || (o_req_ready[l] & ~req_valid[l]) != 4'b0) begin n_err++; $display("[TB] FAIL soak_onehot lane%0d cyc%0d: got %b with valid %b", l, cyc, o_req_ready[l], req_valid[l]); end
        n_cmp++; if (o_astall[l] !== (o_rsp_valid[l] & ~rsp_ready[l])) begin n_err++; $display("[TB] FAIL soak_astall lane%0d cyc%0d: got %b expected %b", l, cyc, o_astall[l], o_rsp_valid[l] & ~rsp_ready[l]); end
        if (o_rsp_valid[l] && rsp_ready[l]) begin
          qs  = (l == 0) ? sbq0.size() : sbq1.size();
          ent = '0;
          n_cmp++;
          if (qs == 0) begin
            n_err++; $display("[TB] FAIL soak_unexpected lane%0d cyc%0d: got id=%0d expected no response", l, cyc, o_rsp_id[l]);
          end else begin
            if (l == 0) ent = sbq0.pop_front(); else ent = sbq1.pop_front();
            if ({o_rsp_id[l], o_rsp_x[l]} !== ent) begin n_err++; $display("[TB] FAIL soak_result lane%0d cyc%0d: got id=%0d x=%h expected id=%0d x=%h", l, cyc, o_rsp_id[l], o_rsp_x[l], ent[38:37], ent[36:0]); end
          end
        end
        acc[l] = req_valid[l] & o_req_ready[l];
        for (int i = 0; i < 4; i++) begin
          if (acc[l][i]) begin
            if (l == 0) sbq0.push_back({2'(i), exp_x(l, i)});
            else        sbq1.push_back({2'(i), exp_x(l, i)});
          end
        end
      end
    end
    n_cmp++; if (sbq0.size() != 0) begin n_err++; $display("[TB] FAIL soak_drain lane0: got %0d outstanding expected 0", sbq0.size()); end
    n_cmp++; if (sbq1.size() != 0) begin n_err++; $display("[TB] FAIL soak_drain lane1: got %0d outstanding expected 0", sbq1.size()); end
  endtask

  initial begin
    aresetn = 1'b0;
    for (int l = 0; l < 2; l++) begin
      req_sign[l] = '0;
      req_exp[l]  = '0;
      req_man[l]  = '0;
    end
    idle_inputs();
    $display("[TB] start");
    test_reset();
    test_all_valid();
    test_single_op();
    test_wrap();
    test_backpressure();
    test_reset_midflight();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/float_rcp_share_ctrl.md
Name: float_rcp_share_ctrl

Overview:
Shares one pipelined float reciprocal datapath (E8/M23 in, 37-bit x out) between N_REQ requesters.
- Arbitrates issue round-robin with valid/ready handshakes.
- Tracks the requester ID and valid bit of each operation through a tag pipe that runs in lock-step with the datapath registers.
- Returns results on a single response channel with backpressure.
- Sits between the SFU issue stage (div/rsqrt front ends) and the reciprocal unit; it drives the unit's operand inputs and its stall input.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width, equal to clog2(N_REQ)
LAT, 1, datapath register stages between operand input and x output (the stall-gated stages)
X_W, 37, reciprocal result width

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset, sampled on the rising edge of aclk
req_valid  in  N_REQ  per-requester operand valid
req_ready  out  N_REQ  per-requester accept; one-hot or zero
req_sign  in  N_REQ  operand sign, one bit per requester
req_exp  in  8*N_REQ  operand exponent; requester i occupies bits [8i+7:8i]
req_man  in  23*N_REQ  operand mantissa; requester i occupies bits [23i+22:23i]
rcp_a_sign  out  1  muxed operand sign to the datapath
rcp_a_exp  out  8  muxed operand exponent to the datapath
rcp_a_man  out  23  muxed operand mantissa to the datapath
rcp_astall  out  1  datapath stall; high freezes all datapath registers
rcp_x  in  X_W  datapath result
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accept
rsp_id  out  ID_W  requester ID of the result
rsp_x  out  X_W  result; equals rcp_x
busy  out  1  any tag stage valid
inflight  out  ID_W+2  count of valid tag stages (0..LAT)

Behaviour:
Reset (aresetn low at a rising edge):
- All tag valid bits clear; rr_ptr = 0.
- Reset holds the whole cycle: req_ready = 0, rsp_valid = 0, busy = 0, inflight = 0.
- Datapath registers have no reset; tag valid is the sole qualifier.
- Reset mid-flight drops every in-flight operation silently. The first cycle after reset deassertion behaves as empty.

Stall:
- rcp_astall = tag_v[LAT-1] & ~rsp_ready, combinational.
- When rcp_astall = 1, the tag pipe holds and no issue occurs.
- An empty tail never stalls. No bubble collapsing.

Arbitration:
- Candidates are req_valid when rcp_astall = 0.
- Round-robin search starts at rr_ptr and takes the lowest index at or above rr_ptr, wrapping to 0.
- The grant is combinational: req_ready[g] = 1 for the winner only.
- A handshake fires when req_valid[g] & req_ready[g]. On fire, rr_ptr <= g+1 mod N_REQ. With no grant, rr_ptr holds.
- The operand mux drives rcp_a_* from the granted requester. With no grant, rcp_a_* = requester rr_ptr (don't-care) and tag_v[0] is written 0.

Tag pipe (advances when rcp_astall = 0):
- tag_v[0] <= fire; tag_id[0] <= g.
- tag[k] <= tag[k-1] for k = 1..LAT-1.
- When rcp_astall = 1, all stages hold, matching the datapath hold.

Response:
- rsp_valid = tag_v[LAT-1]; rsp_id = tag_id[LAT-1]; rsp_x = rcp_x.
- A transfer occurs when rsp_valid & rsp_ready.
- Results return in issue order. Latency from fire to rsp_valid is LAT cycles when no stall occurs.

Simultaneous events:
- A response transfer and a new issue in the same cycle are both allowed, giving full throughput of 1 op/cycle.
- When rsp_ready = 0 with the tail valid, issue blocks that cycle even if earlier stages hold bubbles.

inflight: combinational popcount of tag_v.

Requester rules:
- Once raised, req_valid must hold, with stable operands, until its ready.
- The controller does not check this; the bench asserts it.

Decomposition:
Package float_rcp_share_pkg:
- Constants N_REQ_MAX = 8 and RCP_X_W = 37.
- typedef rcp_tag_t {logic v; logic [ID_W-1:0] id}.
- Function rr_pick(valid, ptr), returning one-hot grant plus index.

Sub-module float_rcp_rr_arb: parameterized round-robin arbiter with inputs req, ptr and enable, and outputs gnt (one-hot) and idx. It is purely combinational. The pointer register lives in the parent.

Test Plan:
- Single op: req 2 sends sign=0, exp=127, man=0 (1.0) with LAT=1 -> req_ready[2]=1 in cycle 0; rsp_valid=1, rsp_id=2 in cycle 1; rsp_x equals the datapath model for 1.0; inflight 1 -> 0.
- All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1 in consecutive cycles; rsp_id follows the same order one cycle later; no idle cycles.
- Backpressure: ops from req 1 then req 3, rsp_ready=0 for 3 cycles when rsp_valid rises -> rcp_astall=1 for those 3 cycles; req_ready=0; rsp_id=1 held stable; rsp_x stable; then ids 1 then 3 delivered, none lost or duplicated.
- Wrap and pointer: rr_ptr=3, only req 0 and req 2 valid -> req 0 granted, rr_ptr becomes 1, next grant is req 2.
- Reset mid-flight: three ops issued with LAT=3, aresetn low one cycle while inflight=2 -> rsp_valid=0 and inflight=0 the next cycle; the next issue uses rr_ptr=0 and no stale response appears.
- Random soak: 10k cycles, random valid/ready, LAT in {1,3} -> scoreboard requires per-requester FIFO ordering, each result matching the model, and req_ready always one-hot or zero.
